// File: rtl/fractal_sync_initiator.sv
// Core-side requester for the fractal synchronization tree: one barrier at a time, sync beat out, wake back, done to core.
// Optional wait-state timeout enabled by defining FRACTAL_SYNC_INITIATOR_TIMEOUT_EN.
module fractal_sync_initiator #(
  parameter int unsigned LVL_WIDTH      = 4,
  parameter int unsigned ID_WIDTH       = 2,
  parameter int unsigned N_REGS         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [LVL_WIDTH-1:0] lvl_i,
  input  logic [ID_WIDTH-1:0]  id_i,
  output logic                 gnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 sync_valid_o,
  input  logic                 sync_ready_i,
  output logic [LVL_WIDTH-1:0] sync_lvl_o,
  output logic [ID_WIDTH-1:0]  sync_id_o,
  input  logic                 wake_valid_i,
  input  logic [LVL_WIDTH-1:0] wake_lvl_i,
  input  logic [ID_WIDTH-1:0]  wake_id_i,
  input  logic                 wake_err_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  if (N_REGS > (32'd1 << ID_WIDTH)) begin : g_bad_n_regs
    $fatal(1, "N_REGS exceeds the id field range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $fatal(1, "TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]           state_q, state_d;
  logic [LVL_WIDTH-1:0] lvl_q, lvl_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic                 err_q, err_d;
  logic                 illegal_c;
  logic                 wake_match_c;

  assign illegal_c    = (lvl_q == '0) || (32'(id_q) >= N_REGS);
  assign wake_match_c = wake_valid_i && (wake_lvl_i == lvl_q) && (wake_id_i == id_q);

`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;

  // Counter value equals completed unmatched WAIT cycles; limit reached on the last one.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      id_q    <= id_d;
      err_q   <= err_d;
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          lvl_d   = lvl_i;
          id_d    = id_i;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal_c) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (sync_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A match on the limit cycle takes priority over the timeout.
        if (wake_match_c) begin
          err_d   = wake_err_i;
          state_d = S_RESP;
        end
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
        else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
    cnt_d = ((state_q == S_WAIT) && (state_d == S_WAIT)) ? cnt_q + CNT_W'(1) : '0;
`endif
  end

  assign gnt_o        = (state_q == S_IDLE) && req_i;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_RESP);
  assign err_o        = (state_q == S_RESP) && err_q;
  assign sync_valid_o = (state_q == S_SEND);
  assign sync_lvl_o   = lvl_q;
  assign sync_id_o    = id_q;

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Scoreboard bench for fractal_sync_initiator: directed requests push expected sync beats and done responses.
module tb_fractal_sync_initiator;

  localparam int unsigned LW = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    logic [LW-1:0] lvl;
    logic [IW-1:0] id;
  } sync_exp_t;

  typedef struct {
    logic        err;
    int unsigned cyc;
  } done_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [LW-1:0] lvl = '0;
  logic [IW-1:0] id = '0;
  logic          gnt, busy, done, err, sync_valid;
  logic          sync_ready = 1'b0;
  logic [LW-1:0] sync_lvl;
  logic [IW-1:0] sync_id;
  logic          wake_valid = 1'b0;
  logic [LW-1:0] wake_lvl = '0;
  logic [IW-1:0] wake_id = '0;
  logic          wake_err = 1'b0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned sv_cycles = 0;
  int unsigned t;

  sync_exp_t exp_sync_q[$];
  done_exp_t exp_done_q[$];

  fractal_sync_initiator #(
    .LVL_WIDTH(LW), .ID_WIDTH(IW), .N_REGS(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lvl_i(lvl), .id_i(id),
    .gnt_o(gnt), .busy_o(busy), .done_o(done), .err_o(err),
    .sync_valid_o(sync_valid), .sync_ready_i(sync_ready),
    .sync_lvl_o(sync_lvl), .sync_id_o(sync_id),
    .wake_valid_i(wake_valid), .wake_lvl_i(wake_lvl), .wake_id_i(wake_id),
    .wake_err_i(wake_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle and checks the same-cycle grant.
  task automatic issue(input logic [LW-1:0] l, input logic [IW-1:0] i);
    req = 1'b1;
    lvl = l;
    id  = i;
    #1;
    chk("gnt", 32'(gnt), 32'd1);
  endtask

  task automatic push_sync(input logic [LW-1:0] l, input logic [IW-1:0] i);
    sync_exp_t e;
    e.lvl = l;
    e.id  = i;
    exp_sync_q.push_back(e);
  endtask

  task automatic push_done(input logic e, input int unsigned c);
    done_exp_t d;
    d.err = e;
    d.cyc = c;
    exp_done_q.push_back(d);
  endtask

  task automatic wake(input logic v, input logic [LW-1:0] l, input logic [IW-1:0] i, input logic e);
    wake_valid = v;
    wake_lvl   = l;
    wake_id    = i;
    wake_err   = e;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {25'd0, gnt, busy, done, err, sync_valid, 2'b00}, 32'd0);
    chk({name, "_sync_bus"}, {26'd0, sync_lvl, sync_id}, 32'd0);
  endtask

  // Monitor: sync beats and done pulses are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (sync_valid) begin
      sv_cycles++;
      if (exp_sync_q.size() == 0) begin
        chk("sync_unexpected", 32'(sync_valid), 32'd0);
      end else begin
        chk("sync_lvl", 32'(sync_lvl), 32'(exp_sync_q[0].lvl));
        chk("sync_id", 32'(sync_id), 32'(exp_sync_q[0].id));
        if (sync_ready) void'(exp_sync_q.pop_front());
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        done_exp_t d;
        d = exp_done_q.pop_front();
        chk("done_err", 32'(err), 32'(d.err));
        chk("done_cycle", cyc, d.cyc);
      end
    end else begin
      chk("err_without_done", 32'(err), 32'd0);
    end
  end

  initial begin
    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    sync_ready = 1'b1;
    step();

    // Legal barrier, ready tied high, minimum latency
    t = cyc;
    issue(4'd2, 2'd1);
    push_sync(4'd2, 2'd1);
    push_done(1'b0, t + 4);
    step();
    req = 1'b0;
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_no_valid", 32'(sync_valid), 32'd0);
    step();
    chk("send_valid_t2", 32'(sync_valid), 32'd1);
    step();
    wake(1'b1, 4'd2, 2'd1, 1'b0);
    step();
    wake(1'b0, '0, '0, 1'b0);
    step();
    chk("idle_after_done", 32'(busy), 32'd0);

    // Backpressure: ready low for five SEND cycles
    sync_ready = 1'b0;
    sv_cycles = 0;
    t = cyc;
    issue(4'd3, 2'd2);
    push_sync(4'd3, 2'd2);
    step();
    req = 1'b0;
    step();
    repeat (5) step();
    sync_ready = 1'b1;
    step();
    chk("bp_valid_cycles", sv_cycles, 32'd6);
    chk("bp_in_wait_busy", 32'(busy), 32'd1);
    chk("bp_in_wait_novalid", 32'(sync_valid), 32'd0);
    wake(1'b1, 4'd3, 2'd2, 1'b0);
    push_done(1'b0, t + 9);
    step();
    wake(1'b0, '0, '0, 1'b0);
    step();

    // Illegal requests: level zero, then id beyond N_REGS
    t = cyc;
    issue(4'd0, 2'd0);
    push_done(1'b1, t + 2);
    step();
    req = 1'b0;
    step();
    step();
    t = cyc;
    issue(4'd1, 2'd3);
    push_done(1'b1, t + 2);
    step();
    req = 1'b0;
    step();
    step();
    chk("illegal_idle", 32'(busy), 32'd0);

    // Stray wakes ignored, matching wake carries its error flag
    t = cyc;
    issue(4'd2, 2'd1);
    push_sync(4'd2, 2'd1);
    step();
    req = 1'b0;
    step();
    step();
    wake(1'b1, 4'd2, 2'd0, 1'b1);
    step();
    wake(1'b1, 4'd3, 2'd1, 1'b1);
    step();
    wake(1'b0, '0, '0, 1'b0);
    chk("stray_still_busy", 32'(busy), 32'd1);
    step();
    wake(1'b1, 4'd2, 2'd1, 1'b1);
    push_done(1'b1, t + 7);
    step();
    wake(1'b0, '0, '0, 1'b0);
    step();

    // Reset while waiting drops the barrier silently
    issue(4'd1, 2'd2);
    push_sync(4'd1, 2'd2);
    step();
    req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("mid_reset");
    wake(1'b1, 4'd1, 2'd2, 1'b0);
    step();
    wake(1'b0, '0, '0, 1'b0);
    step();
    chk("post_reset_idle", 32'(busy), 32'd0);
    t = cyc;
    issue(4'd2, 2'd2);
    push_sync(4'd2, 2'd2);
    push_done(1'b0, t + 4);
    step();
    req = 1'b0;
    step();
    step();
    wake(1'b1, 4'd2, 2'd2, 1'b0);
    step();
    wake(1'b0, '0, '0, 1'b0);
    step();

    // No wake: timeout when enabled, otherwise waits indefinitely
    t = cyc;
    issue(4'd3, 2'd0);
    push_sync(4'd3, 2'd0);
    step();
    req = 1'b0;
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
    push_done(1'b1, t + 11);
    repeat (11) step();
    chk("timeout_idle", 32'(busy), 32'd0);
`else
    repeat (100) step();
    chk("no_timeout_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    repeat (3) step();

    chk("sync_queue_drained", 32'(exp_sync_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
